bcd_entry_reg: RTL and testbench



---
 rtl/calc_pkg.sv | 33 +++
 rtl/bcd_msd_finder.sv | 28 ++
 rtl/bcd_entry_reg.sv | 167 ++++++++++++++++
 tb/tb_bcd_entry_reg.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: BCD digit type, operation priority codes and a
// constant-width helper used to size digit counters.
package calc_pkg;

  localparam int         BCD_W   = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  // Decoded operation for the cycle, listed highest priority first.
  typedef enum logic [2:0] {
    OP_NONE,
    OP_CLR,
    OP_LOAD,
    OP_BKSP,
    OP_KEY
`ifdef BCD_SIGN_EN
    ,
    OP_SIGN
`endif
  } op_e;

  // Number of bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_msd_finder.sv
// Combinational scan of a packed BCD word: significant-digit count (index of the
// most-significant nonzero digit plus one) and a flag for any nibble above 9.
module bcd_msd_finder
  import calc_pkg::*;
#(
  parameter int NDIGITS = 3,
  parameter int CW      = 2
) (
  input  logic [BCD_W*NDIGITS-1:0] value_i,
  output logic [CW-1:0]            count_o,
  output logic                     invalid_o
);

  bcd_digit_t nib;

  always_comb begin
    count_o   = '0;
    invalid_o = 1'b0;
    nib       = '0;
    // Ascending scan: the last nonzero digit seen is the most significant one.
    for (int i = 0; i < NDIGITS; i++) begin
      nib = value_i[i*BCD_W +: BCD_W];
      if (nib != '0) count_o = CW'(i + 1);
      if (nib > BCD_MAX) invalid_o = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_entry_reg.sv
// N-digit BCD operand entry register: keypad append, backspace, clear, parallel load.
// Signed-operand ports and state are added when BCD_SIGN_EN is defined.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter  int NDIGITS       = 3,
  parameter  int BLANK_LEADING = 1,
  localparam int CW            = clog2(NDIGITS + 1),
  localparam int DW            = BCD_W * NDIGITS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [BCD_W-1:0]   digit,
  input  logic               keystrobe,
  input  logic               bksp,
  input  logic               clear,
  input  logic               load_en,
  input  logic [DW-1:0]      load_value,
`ifdef BCD_SIGN_EN
  input  logic               sign_toggle,
  input  logic               load_sign,
  output logic               sign,
`endif
  output logic [DW-1:0]      bcd_out,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               reject,
  output logic [NDIGITS-1:0] blank_mask
);

  // Positions at or above the digit count are blank, except the units digit.
  function automatic logic [NDIGITS-1:0] blank_of(input logic [CW-1:0] c);
    logic [NDIGITS-1:0] m;
    m = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      m[i] = (BLANK_LEADING != 0) && (i >= int'(c));
    end
    return m;
  endfunction

  logic [DW-1:0]      bcd_q, bcd_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               reject_q, reject_d;
  logic [NDIGITS-1:0] blank_q, blank_d;
`ifdef BCD_SIGN_EN
  logic               sign_q, sign_d;
`endif

  logic [CW-1:0]      ld_count;
  logic               ld_invalid;
  op_e                op;

  bcd_msd_finder #(
    .NDIGITS (NDIGITS),
    .CW      (CW)
  ) u_ld_scan (
    .value_i   (load_value),
    .count_o   (ld_count),
    .invalid_o (ld_invalid)
  );

  always_comb begin
    op = OP_NONE;
    if (clear)          op = OP_CLR;
    else if (load_en)   op = OP_LOAD;
    else if (bksp)      op = OP_BKSP;
    else if (keystrobe) op = OP_KEY;
`ifdef BCD_SIGN_EN
    else if (sign_toggle) op = OP_SIGN;
`endif
  end

  always_comb begin
    bcd_d    = bcd_q;
    count_d  = count_q;
    reject_d = 1'b0;
`ifdef BCD_SIGN_EN
    sign_d   = sign_q;
`endif
    case (op)
      OP_CLR: begin
        bcd_d   = '0;
        count_d = '0;
`ifdef BCD_SIGN_EN
        sign_d  = 1'b0;
`endif
      end
      OP_LOAD: begin
        if (ld_invalid) begin
          reject_d = 1'b1;
        end else begin
          bcd_d   = load_value;
          count_d = ld_count;
`ifdef BCD_SIGN_EN
          sign_d  = load_sign && (ld_count != '0);
`endif
        end
      end
      OP_BKSP: begin
        if (!empty_q) begin
          bcd_d   = bcd_q >> BCD_W;
          count_d = count_q - CW'(1);
`ifdef BCD_SIGN_EN
          if (count_q == CW'(1)) sign_d = 1'b0;
`endif
        end
      end
      OP_KEY: begin
        if (full_q || (digit > BCD_MAX)) begin
          reject_d = 1'b1;
        end else if (!(empty_q && (digit == '0))) begin
          // Leading zeros are swallowed so count tracks significant digits only.
          bcd_d   = (bcd_q << BCD_W) | DW'(digit);
          count_d = count_q + CW'(1);
        end
      end
`ifdef BCD_SIGN_EN
      OP_SIGN: begin
        if (empty_q) reject_d = 1'b1;
        else         sign_d   = ~sign_q;
      end
`endif
      default: ;
    endcase
    full_d  = (count_d == CW'(NDIGITS));
    empty_d = (count_d == '0);
    blank_d = blank_of(count_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bcd_q    <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reject_q <= 1'b0;
      blank_q  <= blank_of('0);
    end else begin
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      reject_q <= reject_d;
      blank_q  <= blank_d;
    end
  end

`ifdef BCD_SIGN_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sign_q <= 1'b0;
    else       sign_q <= sign_d;
  end

  assign sign = sign_q;
`endif

  assign bcd_out    = bcd_q;
  assign count      = count_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign reject     = reject_q;
  assign blank_mask = blank_q;

endmodule

// File: tb/tb_bcd_entry_reg.sv
// Directed bench for bcd_entry_reg at NDIGITS=3 with leading-digit blanking.
module tb_bcd_entry_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  digit;
  logic        keystrobe, bksp, clear, load_en;
  logic [11:0] load_value;
  logic [11:0] bcd_out;
  logic [1:0]  count;
  logic        full, empty, reject;
  logic [2:0]  blank_mask;
`ifdef BCD_SIGN_EN
  logic        sign_toggle = 1'b0;
  logic        load_sign   = 1'b0;
  logic        sign;
`endif

  int n_vec = 0;
  int n_bad = 0;

  bcd_entry_reg #(.NDIGITS(3), .BLANK_LEADING(1)) dut (
    .clock      (clock),
    .reset      (reset),
    .digit      (digit),
    .keystrobe  (keystrobe),
    .bksp       (bksp),
    .clear      (clear),
    .load_en    (load_en),
    .load_value (load_value),
`ifdef BCD_SIGN_EN
    .sign_toggle(sign_toggle),
    .load_sign  (load_sign),
    .sign       (sign),
`endif
    .bcd_out    (bcd_out),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .reject     (reject),
    .blank_mask (blank_mask)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes, then return 1 time unit after the edge.
  task automatic step(input logic k, input logic [3:0] d, input logic b,
                      input logic c, input logic l, input logic [11:0] lv);
    keystrobe = k; digit = d; bksp = b; clear = c; load_en = l; load_value = lv;
    @(posedge clock); #1;
    keystrobe = 0; bksp = 0; clear = 0; load_en = 0;
  endtask

  task automatic key(input logic [3:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic back();
    step(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic load(input logic [11:0] v);
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b1, v);
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 12'h000);
  endtask

  task automatic check_state(input string tag, input logic [11:0] b, input logic [1:0] c,
                             input logic r, input logic [2:0] m);
    check({tag, ".bcd"},   32'(bcd_out),    32'(b));
    check({tag, ".count"}, 32'(count),      32'(c));
    check({tag, ".full"},  32'(full),       32'(c == 2'd3));
    check({tag, ".empty"}, 32'(empty),      32'(c == 2'd0));
    check({tag, ".rej"},   32'(reject),     32'(r));
    check({tag, ".blank"}, 32'(blank_mask), 32'(m));
  endtask

  initial begin
    reset = 1'b1; digit = '0; keystrobe = 0; bksp = 0; clear = 0; load_en = 0;
    load_value = '0;
    repeat (2) @(posedge clock);
    #1;
    check_state("reset", 12'h000, 2'd0, 1'b0, 3'b110);
    reset = 1'b0;

    key(4'd1); check_state("key1", 12'h001, 2'd1, 1'b0, 3'b110);
    key(4'd2); check_state("key2", 12'h012, 2'd2, 1'b0, 3'b100);
    key(4'd3); check_state("key3", 12'h123, 2'd3, 1'b0, 3'b000);
    key(4'd4); check_state("key4_full", 12'h123, 2'd3, 1'b1, 3'b000);
    idle();    check("rej_pulse_end", 32'(reject), 32'd0);

    back(); check_state("bksp1", 12'h012, 2'd2, 1'b0, 3'b100);
    back(); check_state("bksp2", 12'h001, 2'd1, 1'b0, 3'b110);
    back(); check_state("bksp3", 12'h000, 2'd0, 1'b0, 3'b110);
    back(); check_state("bksp_empty", 12'h000, 2'd0, 1'b0, 3'b110);

    key(4'd0); check_state("lead0", 12'h000, 2'd0, 1'b0, 3'b110);
    key(4'd5); check_state("key5", 12'h005, 2'd1, 1'b0, 3'b110);

    load(12'h045); check_state("load045", 12'h045, 2'd2, 1'b0, 3'b100);
    load(12'h0A1); check_state("load_bad", 12'h045, 2'd2, 1'b1, 3'b100);
    load(12'h900); check_state("load900", 12'h900, 2'd3, 1'b0, 3'b000);
    load(12'h000); check_state("load000", 12'h000, 2'd0, 1'b0, 3'b110);

    load(12'h078);
    step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 12'h999);
    check_state("clr_prio", 12'h000, 2'd0, 1'b0, 3'b110);

    load(12'h078);
    step(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 12'h000);
    check_state("bksp_over_key", 12'h007, 2'd1, 1'b0, 3'b110);
    step(1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 12'h321);
    check_state("load_over_bksp", 12'h321, 2'd3, 1'b0, 3'b000);

    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 12'h000);
    key(4'hB); check_state("key_hexB", 12'h000, 2'd0, 1'b1, 3'b110);

    key(4'd1); key(4'd2);
    check_state("pre_rst", 12'h012, 2'd2, 1'b0, 3'b100);
    #2 reset = 1'b1;
    #1 check_state("async_rst", 12'h000, 2'd0, 1'b0, 3'b110);
    keystrobe = 1'b1; digit = 4'd8;
    @(posedge clock); #1;
    keystrobe = 1'b0;
    check_state("strobe_in_rst", 12'h000, 2'd0, 1'b0, 3'b110);
    reset = 1'b0;
    key(4'd6); check_state("post_rst", 12'h006, 2'd1, 1'b0, 3'b110);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
